// File: rtl/vga_timing_if.sv
// Control and raster-timing bundle between the timing generator and the pixel pipeline.
// The generator (master) receives run/restart and drives the registered timing outputs.
interface vga_timing_if #(
   parameter int unsigned CW = 11
);
   logic          en;
   logic          restart;
   logic          pix_tick;
   logic          hsync;
   logic          vsync;
   logic          vid_on;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      input  en,
      input  restart,
      output pix_tick,
      output hsync,
      output vsync,
      output vid_on,
      output x,
      output y,
      output line_start,
      output frame_start
   );

   modport slave (
      output en,
      output restart,
      input  pix_tick,
      input  hsync,
      input  vsync,
      input  vid_on,
      input  x,
      input  y,
      input  line_start,
      input  frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: integer pixel-rate divider, h/v counters and a
// single registered output stage so every timing output is aligned and glitch-free.
module vga_timing_gen #(
   parameter int unsigned CW      = 11,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned H_DISP  = 640,
   parameter int unsigned H_FP    = 16,
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BP    = 48,
   parameter int unsigned V_DISP  = 480,
   parameter int unsigned V_FP    = 10,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BP    = 33,
   parameter bit          H_POL   = 1'b0,
   parameter bit          V_POL   = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   vga_timing_if.master bus
);

   localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_DISP + H_FP;
   localparam int unsigned HS_END   = H_DISP + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_DISP + V_FP;
   localparam int unsigned VS_END   = V_DISP + V_FP + V_SYNC;
   localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // One extra bit so decode bounds equal to 2^CW still compare correctly.
   localparam int unsigned XW       = CW + 1;

   if (64'(H_TOTAL) > (64'(1) << CW)) begin : g_chk_h
      $error("vga_timing_gen: H_TOTAL exceeds 2^CW");
   end
   if (64'(V_TOTAL) > (64'(1) << CW)) begin : g_chk_v
      $error("vga_timing_gen: V_TOTAL exceeds 2^CW");
   end
   if (CLK_DIV < 1) begin : g_chk_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;

   logic          pix_tick_q;
   logic          hsync_q;
   logic          vsync_q;
   logic          vid_on_q;
   logic [CW-1:0] x_q;
   logic [CW-1:0] y_q;
   logic          line_start_q;
   logic          frame_start_q;

   logic          tick_c;
   logic          h_last_c;
   logic          v_last_c;
   logic          hs_act_c;
   logic          vs_act_c;
   logic          vid_c;
   logic [XW-1:0] h_ext_c;
   logic [XW-1:0] v_ext_c;

   // Counter-state decode; consumed only by the output register stage.
   always_comb begin
      h_ext_c  = {1'b0, h_q};
      v_ext_c  = {1'b0, v_q};
      tick_c   = (div_q == DW'(CLK_DIV - 1));
      h_last_c = (h_q == CW'(H_TOTAL - 1));
      v_last_c = (v_q == CW'(V_TOTAL - 1));
      hs_act_c = (h_ext_c >= XW'(HS_START)) && (h_ext_c < XW'(HS_END));
      vs_act_c = (v_ext_c >= XW'(VS_START)) && (v_ext_c < XW'(VS_END));
      vid_c    = (h_ext_c < XW'(H_DISP)) && (v_ext_c < XW'(V_DISP));
   end

   // Next counter state for an enabled cycle; v only moves on the tick that wraps h.
   always_comb begin
      div_d = div_q + DW'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (tick_c) begin
         div_d = '0;
         if (h_last_c) begin
            h_d = '0;
            v_d = v_last_c ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
         end
      end
   end

   // Divider and raster counters; restart outranks the run enable.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else if (bus.restart) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else if (bus.en) begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // Output stage: one cycle behind the counters, all outputs loaded together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pix_tick_q    <= 1'b0;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         vid_on_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (bus.restart) begin
         pix_tick_q    <= 1'b0;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         vid_on_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (bus.en) begin
         pix_tick_q    <= tick_c;
         hsync_q       <= hs_act_c ? H_POL : ~H_POL;
         vsync_q       <= vs_act_c ? V_POL : ~V_POL;
         vid_on_q      <= vid_c;
         x_q           <= vid_c ? h_q : '0;
         y_q           <= vid_c ? v_q : '0;
         line_start_q  <= tick_c && (h_q == '0);
         frame_start_q <= tick_c && (h_q == '0) && (v_q == '0);
      end
   end

   assign bus.pix_tick    = pix_tick_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.vid_on      = vid_on_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small active-high raster at two divider settings
// and the default 640x480 timing over one line.
module tb_vga_timing_gen;

   localparam int unsigned CW = 11;
   localparam int unsigned PW = 2 * CW + 6;

   typedef struct {
      int            k;
      logic [PW-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_d;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   vga_timing_if #(.CW(CW)) bus_a ();
   vga_timing_if #(.CW(CW)) bus_b ();
   vga_timing_if #(.CW(CW)) bus_d ();

   vga_timing_gen #(
      .CW(CW), .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
   ) dut_a (.i_clk(clk), .i_rst_n(rst_a), .bus(bus_a));

   vga_timing_gen #(
      .CW(CW), .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
   ) dut_b (.i_clk(clk), .i_rst_n(rst_b), .bus(bus_b));

   vga_timing_gen #(.CW(CW)) dut_d (.i_clk(clk), .i_rst_n(rst_d), .bus(bus_d));

   function automatic logic [PW-1:0] pk(input logic t, input logic hs, input logic vs,
                                        input logic vid, input int x, input int y,
                                        input logic ls, input logic fs);
      return {t, hs, vs, vid, CW'(x), CW'(y), ls, fs};
   endfunction

   function automatic logic [PW-1:0] obs_a();
      return {bus_a.pix_tick, bus_a.hsync, bus_a.vsync, bus_a.vid_on,
              bus_a.x, bus_a.y, bus_a.line_start, bus_a.frame_start};
   endfunction

   function automatic logic [PW-1:0] obs_b();
      return {bus_b.pix_tick, bus_b.hsync, bus_b.vsync, bus_b.vid_on,
              bus_b.x, bus_b.y, bus_b.line_start, bus_b.frame_start};
   endfunction

   function automatic logic [PW-1:0] obs_d();
      return {bus_d.pix_tick, bus_d.hsync, bus_d.vsync, bus_d.vid_on,
              bus_d.x, bus_d.y, bus_d.line_start, bus_d.frame_start};
   endfunction

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got {tick,hs,vs,vid,x,y,ls,fs}=%h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // n rising edges, then settle on the following falling edge.
   task automatic adv(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      vec_t va[17];
      int   ka;
      int   ticks, fss;
      int   ls_edge, hs_edge, hs_low, vs_low, vid_ticks;

      // Edge index after reset release -> expected outputs, small raster, CLK_DIV=2.
      va[0]  = '{0,   pk(0, 0, 0, 0, 0, 0, 0, 0)};
      va[1]  = '{1,   pk(0, 0, 0, 1, 0, 0, 0, 0)};
      va[2]  = '{2,   pk(1, 0, 0, 1, 0, 0, 1, 1)};
      va[3]  = '{3,   pk(0, 0, 0, 1, 1, 0, 0, 0)};
      va[4]  = '{4,   pk(1, 0, 0, 1, 1, 0, 0, 0)};
      va[5]  = '{16,  pk(1, 0, 0, 1, 7, 0, 0, 0)};
      va[6]  = '{18,  pk(1, 0, 0, 0, 0, 0, 0, 0)};
      va[7]  = '{22,  pk(1, 1, 0, 0, 0, 0, 0, 0)};
      va[8]  = '{26,  pk(1, 1, 0, 0, 0, 0, 0, 0)};
      va[9]  = '{28,  pk(1, 0, 0, 0, 0, 0, 0, 0)};
      va[10] = '{32,  pk(1, 0, 0, 1, 0, 1, 1, 0)};
      va[11] = '{106, pk(1, 0, 0, 1, 7, 3, 0, 0)};
      va[12] = '{122, pk(1, 0, 0, 0, 0, 0, 1, 0)};
      va[13] = '{152, pk(1, 0, 1, 0, 0, 0, 1, 0)};
      va[14] = '{180, pk(1, 0, 1, 0, 0, 0, 0, 0)};
      va[15] = '{181, pk(0, 0, 0, 0, 0, 0, 0, 0)};
      va[16] = '{212, pk(1, 0, 0, 1, 0, 0, 1, 1)};

      rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0;
      bus_a.en = 1'b1; bus_a.restart = 1'b0;
      bus_b.en = 1'b1; bus_b.restart = 1'b0;
      bus_d.en = 1'b1; bus_d.restart = 1'b0;
      repeat (3) @(negedge clk);

      // Small raster, CLK_DIV=2, active-high syncs.
      rst_a = 1'b1;
      ka = 0;
      for (int i = 0; i < 17; i++) begin
         adv(va[i].k - ka);
         ka = va[i].k;
         chk($sformatf("a_vec%0d_k%0d", i, va[i].k), obs_a(), va[i].exp);
      end

      // Hold mid-line after the x=5 tick; strobes and outputs must freeze.
      adv(10);
      chk("a_pre_hold", obs_a(), pk(1, 0, 0, 1, 5, 0, 0, 0));
      bus_a.en = 1'b0;
      adv(17);
      chk("a_in_hold", obs_a(), pk(1, 0, 0, 1, 5, 0, 0, 0));
      bus_a.en = 1'b1;
      adv(1);
      chk("a_resume1", obs_a(), pk(0, 0, 0, 1, 6, 0, 0, 0));
      adv(1);
      chk("a_resume_tick", obs_a(), pk(1, 0, 0, 1, 6, 0, 0, 0));
      // Frame period stretched by exactly the 17 held cycles.
      adv(197);
      chk("a_fs_minus1", obs_a(), pk(0, 0, 0, 1, 0, 0, 0, 0));
      adv(1);
      chk("a_fs_after_hold", obs_a(), pk(1, 0, 0, 1, 0, 0, 1, 1));

      // Counters now reach v=3,h=9; restart together with en low.
      adv(106);
      chk("a_pre_restart", obs_a(), pk(1, 0, 0, 0, 0, 0, 0, 0));
      bus_a.restart = 1'b1; bus_a.en = 1'b0;
      adv(1);
      chk("a_restart", obs_a(), pk(0, 0, 0, 0, 0, 0, 0, 0));
      bus_a.restart = 1'b0; bus_a.en = 1'b1;
      adv(1);
      chk("a_restart_e1", obs_a(), pk(0, 0, 0, 1, 0, 0, 0, 0));
      adv(1);
      chk("a_restart_e2", obs_a(), pk(1, 0, 0, 1, 0, 0, 1, 1));

      // Async reset in the middle of the hsync pulse.
      adv(22);
      chk("a_mid_hsync", obs_a(), pk(1, 1, 0, 0, 0, 0, 0, 0));
      rst_a = 1'b0;
      #1;
      chk("a_async_rst", obs_a(), pk(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_a = 1'b1;
      adv(1);
      chk("a_rst_e1", obs_a(), pk(0, 0, 0, 1, 0, 0, 0, 0));
      adv(1);
      chk("a_rst_e2", obs_a(), pk(1, 0, 0, 1, 0, 0, 1, 1));

      // Same raster with CLK_DIV=1: tick every enabled cycle, 105-cycle frame.
      rst_b = 1'b1;
      chk("b_reset", obs_b(), pk(0, 0, 0, 0, 0, 0, 0, 0));
      adv(1);
      chk("b_e1", obs_b(), pk(1, 0, 0, 1, 0, 0, 1, 1));
      adv(1);
      chk("b_e2", obs_b(), pk(1, 0, 0, 1, 1, 0, 0, 0));
      adv(7);
      chk("b_e9", obs_b(), pk(1, 0, 0, 0, 0, 0, 0, 0));
      adv(2);
      chk("b_e11", obs_b(), pk(1, 1, 0, 0, 0, 0, 0, 0));
      ticks = 0; fss = 0;
      for (int e = 12; e <= 105; e++) begin
         adv(1);
         if (bus_b.pix_tick)    ticks++;
         if (bus_b.frame_start) fss++;
      end
      chk_int("b_tick_count", ticks, 94);
      chk_int("b_fs_count", fss, 0);
      adv(1);
      chk("b_e106", obs_b(), pk(1, 0, 0, 1, 0, 0, 1, 1));

      // Default 640x480 timing, CLK_DIV=4, active-low syncs, over one full line.
      rst_d = 1'b1;
      chk("d_reset", obs_d(), pk(0, 1, 1, 0, 0, 0, 0, 0));
      adv(4);
      chk("d_first_pixel", obs_d(), pk(1, 1, 1, 1, 0, 0, 1, 1));
      ls_edge = -1; hs_edge = -1; hs_low = 0; vs_low = 0; vid_ticks = 0;
      for (int e = 5; e <= 3204; e++) begin
         adv(1);
         if (!bus_d.hsync) hs_low++;
         if (!bus_d.vsync) vs_low++;
         if (bus_d.pix_tick && bus_d.vid_on) vid_ticks++;
         if (bus_d.pix_tick && !bus_d.hsync && hs_edge < 0) hs_edge = e;
         if (bus_d.line_start && ls_edge < 0) ls_edge = e;
      end
      chk_int("d_line_period", ls_edge - 4, 3200);
      chk_int("d_hsync_offset", hs_edge - 4, 2624);
      chk_int("d_hsync_width", hs_low, 384);
      chk_int("d_vid_ticks", vid_ticks, 640);
      chk_int("d_vsync_idle", vs_low, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator. Successor to the fixed 640x480 controller.
- All porch, sync and display extents are parameters, and sync polarity is selectable.
- Pixel-rate enable is derived from i_clk by an integer divider. Adds run/hold control, synchronous restart, frame/line start strobes and registered, glitch-free outputs.
- Sits between the system clock domain and the pixel pipeline (pattern/framebuffer readers consume o_x, o_y, o_vid_on, o_pix_tick).

Parameters:
- CW, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be <= 2^CW (elaboration check, $error if violated).
- CLK_DIV, 4, i_clk cycles per pixel; 1 = every cycle; must be >= 1.
- H_DISP, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_DISP, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level (0 = active-low).
- Derived: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL likewise.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  run enable; low freezes divider, counters and outputs.
- i_restart  in  1  synchronous restart to (0,0), divider cleared.
- o_pix_tick  out  1  one-i_clk strobe marking a new pixel on outputs.
- o_hsync  out  1  horizontal sync, polarity H_POL.
- o_vsync  out  1  vertical sync, polarity V_POL.
- o_vid_on  out  1  high inside active area.
- o_x  out  CW  active column, 0..H_DISP-1; 0 when o_vid_on low.
- o_y  out  CW  active row, 0..V_DISP-1; 0 when o_vid_on low.
- o_line_start  out  1  strobe coincident with o_pix_tick when h=0.
- o_frame_start  out  1  strobe coincident with o_pix_tick when h=0 and v=0.

Behaviour:
- Reset values (async assert, sync-safe deassert not required inside block):
  - div, h, v = 0.
  - o_pix_tick, o_vid_on, o_line_start, o_frame_start = 0.
  - o_x, o_y = 0.
  - o_hsync = ~H_POL; o_vsync = ~V_POL (inactive).
- Divider: div counts 0..CLK_DIV-1 on each i_clk with i_en=1. tick = (div==CLK_DIV-1). Wraps to 0 on tick. CLK_DIV=1: tick every enabled cycle.
- Line order is display, front porch, sync, back porch. Counter h = column index.
- On tick:
  - h increments.
  - At h==H_TOTAL-1: h wraps to 0 and v advances.
  - v wraps to 0 at V_TOTAL-1.
  - v changes only on the same tick that h wraps.
- Decode (of counter state):
  - hs_act = H_DISP+H_FP <= h < H_DISP+H_FP+H_SYNC.
  - vs_act = V_DISP+V_FP <= v < V_DISP+V_FP+V_SYNC.
  - vid = h<H_DISP and v<V_DISP.
- Output register stage:
  - Every i_clk with i_en=1, outputs load the decode of current (h,v).
  - o_pix_tick loads tick.
  - Outputs therefore lag counters by exactly 1 i_clk and are mutually aligned.
  - o_hsync = hs_act ? H_POL : ~H_POL; o_vsync likewise.
- First pixel after reset: o_pix_tick first asserts CLK_DIV i_clk cycles after reset release, with o_frame_start=1, o_line_start=1, o_vid_on=1, o_x=0, o_y=0.
- Hold (i_en=0): div, h, v and all outputs hold. Strobes hold their value and are not regenerated. Resuming continues exactly where it stopped.
- Restart (i_restart=1): on next edge div, h, v = 0 and outputs return to reset values. Priority over i_en. Next tick behaves as first pixel after reset.
- Restart mid-frame truncates the frame; no partial sync pulse is stretched.
- Async reset mid-operation: immediate return to reset values regardless of i_en or i_restart.
- Simultaneous h wrap and v wrap on one tick: both counters become 0 together. Frame_start appears on the following output update.
- Sync widths are exact pixel/line counts at any CLK_DIV. No combinational path from counters to outputs.

Test Plan:
- Defaults, CLK_DIV=4, run 2 frames:
  - o_hsync low for 96 ticks (384 i_clk) starting at o_x column 656.
  - Line period 3200 i_clk.
  - o_vsync low exactly 2 lines starting line 490.
  - Frame period 1,680,000 i_clk; exactly 640*480 ticks per frame with o_vid_on=1.
- Small config H=8/2/3/2, V=4/1/1/1, CLK_DIV=2, H_POL=V_POL=1:
  - Line = 15 ticks = 30 i_clk; hsync high at h 10..12.
  - Frame = 7 lines; o_frame_start every 210 i_clk.
  - o_x sequence 0..7, then 0 outside display.
- Same config, CLK_DIV=1: o_pix_tick continuously high while enabled; frame_start every 105 i_clk.
- Drop i_en for 17 cycles mid-line at h=5: all outputs frozen; after resume the next tick shows o_x=6, and frame period extends by exactly 17 i_clk.
- Assert i_restart at v=3, h=9 together with i_en=0: outputs go to reset values; first tick after 2 i_clk shows o_frame_start=1, o_x=0, o_y=0.
- Async reset pulse mid-hsync (active-high config): o_hsync drops to 0 within the reset assertion; after release the restart sequence matches the first-pixel-after-reset timing.
